// File: rtl/arb2_mux_ctrl_pkg.sv
// Shared definitions for the two-requester round-robin arbiter: state encodings,
// the default burst cap and the grant-pick rule used in IDLE.
package arb2_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_BURST_DEF = 4;

    // Both requesting: the pointer wins. Otherwise the lone requester wins.
    function automatic logic pick_idx(input logic [1:0] v, input logic ptr);
        return (v == 2'b11) ? ptr : v[1];
    endfunction

endpackage

// File: rtl/arb2_mux_ctrl_mux2x1.sv
// Single-bit 2:1 data-path multiplexer cell; din[0] when sel=0, din[1] when sel=1.
module mux2x1 (
    input  logic [1:0] din,
    input  logic       sel,
    output logic       y
);
    assign y = din[sel];
endmodule

// File: rtl/arb2_mux_ctrl.sv
// Two-requester round-robin arbiter with burst cap and a registered output stage.
// Owns the data-path mux select; beats pass through mux2x1 cells into out_*.
module arb2_mux_ctrl
    import arb2_mux_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = ARB_MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_last,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              ov_q, ov_d;
    logic [DATA_W-1:0] od_q, od_d;
    logic              ol_q, ol_d;
    logic              os_q, os_d;

    logic [DATA_W-1:0] mux_data;
    logic              mux_last;
    logic              grant_idx;
    logic              beat_acc;
    logic              burst_end;

    for (genvar i = 0; i < DATA_W; i++) begin : g_dmux
        mux2x1 u_mux (
            .din ({req_data1[i], req_data0[i]}),
            .sel (sel_q),
            .y   (mux_data[i])
        );
    end

    mux2x1 u_lmux (
        .din ({req_last[1], req_last[0]}),
        .sel (sel_q),
        .y   (mux_last)
    );

    // In either GRANT state sel_q already equals the granted index.
    assign grant_idx = (state_q == ST_GRANT1);
    assign beat_acc  = |(req_valid & req_ready);
    assign burst_end = mux_last | (cnt_q == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid)
                    state_d = pick_idx(req_valid, ptr_q) ? ST_GRANT1 : ST_GRANT0;
            end
            ST_GRANT0, ST_GRANT1: begin
                if (beat_acc && burst_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        busy      = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                busy         = 1'b1;
                req_ready[0] = ~ov_q | out_ready;
            end
            ST_GRANT1: begin
                busy         = 1'b1;
                req_ready[1] = ~ov_q | out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        ov_d  = ov_q;
        od_d  = od_q;
        ol_d  = ol_q;
        os_d  = os_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (|req_valid) sel_d = pick_idx(req_valid, ptr_q);
        end
        if (beat_acc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (burst_end) ptr_d = ~grant_idx;
            ov_d = 1'b1;
            od_d = mux_data;
            ol_d = mux_last;
            os_d = grant_idx;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
            cnt_q <= '0;
            sel_q <= 1'b0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            ol_q  <= 1'b0;
            os_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            ov_q  <= ov_d;
            od_q  <= od_d;
            ol_q  <= ol_d;
            os_q  <= os_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign out_src   = os_q;

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Randomized bench for arb2_mux_ctrl: burst-queue sources, a grant-owner reference
// model, and a per-source in-order scoreboard on the output stream.
module tb_arb2_mux_ctrl;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_last = '0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic [1:0]    req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_src;
    logic          out_ready = 1'b0;
    logic          sel;
    logic          busy;

    arb2_mux_ctrl #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // {last, data} beats waiting at each source, and beats owed on the output
    logic [8:0] src0_q[$], src1_q[$];
    logic [8:0] exp0_q[$], exp1_q[$];

    // Reference model: who owns the channel, how many beats it has taken,
    // who is preferred next, and what the output register should hold.
    int         owner;
    int         taken;
    int         pref;
    logic       m_sel;
    logic       m_ov;
    logic [7:0] m_od;
    logic       m_ol;
    logic       m_os;

    task automatic reset_model();
        owner = -1; taken = 0; pref = 0;
        m_sel = 1'b0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 1'b0;
    endtask

    task automatic push_burst(input int i);
        int len;
        logic [8:0] b;
        len = int'($urandom_range(1, 6));
        for (int k = 0; k < len; k++) begin
            b = {(k == len - 1), 8'($urandom)};
            if (i == 0) src0_q.push_back(b);
            else        src1_q.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string ph);
        chk({ph, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({ph, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({ph, "_out_data"},  32'(out_data),  32'd0);
        chk({ph, "_out_last"},  32'(out_last),  32'd0);
        chk({ph, "_out_src"},   32'(out_src),   32'd0);
        chk({ph, "_sel"},       32'(sel),       32'd0);
        chk({ph, "_busy"},      32'(busy),      32'd0);
    endtask

    // One cycle: drive at negedge, check after settling, then advance the model
    // to what the coming posedge should produce.
    task automatic step(input bit refill, input int vprob, input int rprob);
        logic [1:0] e_rdy, acc;
        logic [8:0] b, e;
        int idx;
        @(negedge clk);
        if (refill) begin
            if (src0_q.size() < 3) push_burst(0);
            if (src1_q.size() < 3) push_burst(1);
        end
        req_valid[0] = (src0_q.size() > 0) && (int'($urandom_range(0, 99)) < vprob);
        req_valid[1] = (src1_q.size() > 0) && (int'($urandom_range(0, 99)) < vprob);
        b = (src0_q.size() > 0) ? src0_q[0] : 9'($urandom);
        {req_last[0], req_data0} = b;
        b = (src1_q.size() > 0) ? src1_q[0] : 9'($urandom);
        {req_last[1], req_data1} = b;
        out_ready = int'($urandom_range(0, 99)) < rprob;
        #1;
        e_rdy = 2'b00;
        if (owner >= 0) e_rdy[owner] = !m_ov || out_ready;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_od));
            chk("out_last", 32'(out_last), 32'(m_ol));
            chk("out_src",  32'(out_src),  32'(m_os));
        end
        chk("sel",  32'(sel),  32'(m_sel));
        chk("busy", 32'(busy), 32'(owner >= 0));
        if (out_valid && out_ready) begin
            if ((out_src ? exp1_q.size() : exp0_q.size()) == 0) begin
                chk("sb_unexpected_beat", 32'(out_src), 32'hffff_ffff);
            end else begin
                e = out_src ? exp1_q.pop_front() : exp0_q.pop_front();
                chk("sb_beat", 32'({out_last, out_data}), 32'(e));
            end
        end

        acc = req_valid & e_rdy;
        if (acc != 2'b00) begin
            idx = acc[1] ? 1 : 0;
            b = (idx == 1) ? src1_q.pop_front() : src0_q.pop_front();
            if (idx == 1) exp1_q.push_back(b);
            else          exp0_q.push_back(b);
            m_ov = 1'b1; m_ol = b[8]; m_od = b[7:0]; m_os = idx[0];
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (owner < 0) begin
            if (req_valid != 2'b00) begin
                owner = (req_valid == 2'b11) ? pref : (req_valid[1] ? 1 : 0);
                m_sel = owner[0];
                taken = 0;
            end
        end else if (acc[owner]) begin
            taken++;
            if (b[8] || taken == MB) begin
                pref  = 1 - owner;
                owner = -1;
            end
        end
    endtask

    initial begin
        bit hit;
        reset_model();
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention, caps (bursts up to 6 beats) and random backpressure
        for (int c = 0; c < 1500; c++) step(1'b1, 85, 70);
        // Heavier backpressure stretch
        for (int c = 0; c < 300; c++) step(1'b1, 90, 25);

        // Asynchronous reset while req1 owns the channel with a beat held
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            step(1'b1, 85, 50);
            if (owner == 1 && m_ov) hit = 1'b1;
        end
        chk("midrst_reached", 32'(hit), 32'd1);
        @(posedge clk);
        #2;
        chk("midrst_pre_busy",  32'(busy),      32'(owner >= 0));
        chk("midrst_pre_valid", 32'(out_valid), 32'(m_ov));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset_model();
        src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone req1 after reset, then more random traffic
        push_burst(1);
        for (int c = 0; c < 12; c++) step(1'b0, 100, 100);
        for (int c = 0; c < 800; c++) step(1'b1, 70, 60);

        // Drain: everything sent must come out, bounded
        for (int c = 0; c < 600; c++) begin
            if (src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size() == 0 && !m_ov) break;
            step(1'b0, 100, 80);
        end
        chk("drain_left", 32'(src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
